// File: rtl/regfile_writeback_arbiter.sv
// Sequences ALU and buffered load/store results onto the single register-file write port, with a RAW pending scoreboard.
// Latency: 1 cycle, grant to rf_* outputs. Backpressure: alu_ready only when granted; lsu_ready drops while the FIFO is full.
module regfile_writeback_arbiter #(
    parameter  int WORD            = 32,
    parameter  int REGISTER_NUMBER = 32,
    parameter  int FIFO_DEPTH      = 4,
    localparam int RW              = $clog2(REGISTER_NUMBER),
    localparam int CW              = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       alu_valid,
    input  logic [RW-1:0]              alu_rd,
    input  logic [WORD-1:0]            alu_data,
    output logic                       alu_ready,
    input  logic                       lsu_valid,
    input  logic [RW-1:0]              lsu_rd,
    input  logic [WORD-1:0]            lsu_data,
    output logic                       lsu_ready,
    input  logic                       issue_mark,
    input  logic [RW-1:0]              issue_rd,
    output logic [REGISTER_NUMBER-1:0] pending,
    output logic                       rf_write_enable,
    output logic [RW-1:0]              rf_write_select,
    output logic [WORD-1:0]            rf_data_in,
    output logic [CW-1:0]              fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [RW-1:0]   rd;
        logic [WORD-1:0] data;
    } wb_entry_t;

    wb_entry_t                  mem_q [FIFO_DEPTH];
    wb_entry_t                  mem_d [FIFO_DEPTH];
    logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]              count_q, count_d;
    logic [REGISTER_NUMBER-1:0] pending_q, pending_d;
    logic                       we_q, we_d;
    logic [RW-1:0]              sel_q, sel_d;
    logic [WORD-1:0]            data_q, data_d;

    logic      fifo_full;
    logic      fifo_empty;
    logic      push;
    logic      grant_fifo;
    logic      grant_alu;
    logic      grant;
    wb_entry_t winner;

    // A full FIFO takes priority so the load path can never be starved by a busy ALU.
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign push       = lsu_valid && !fifo_full;
    assign grant_fifo = fifo_full || (!alu_valid && !fifo_empty);
    assign grant_alu  = alu_valid && !fifo_full;
    assign grant      = grant_fifo || grant_alu;
    assign winner     = grant_fifo ? mem_q[rd_ptr_q] : {alu_rd, alu_data};

    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = {lsu_rd, lsu_data};
        end
        wr_ptr_d = push       ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = grant_fifo ? rd_ptr_q + PW'(1) : rd_ptr_q;
        case ({push, grant_fifo})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        we_d   = grant && (winner.rd != '0);
        sel_d  = grant ? winner.rd   : sel_q;
        data_d = grant ? winner.data : data_q;

        // Clear first, then set, so a same-cycle reservation survives the retiring write.
        pending_d = pending_q;
        if (grant && (winner.rd != '0)) begin
            pending_d[winner.rd] = 1'b0;
        end
        if (issue_mark && (issue_rd != '0)) begin
            pending_d[issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            pending_q <= '0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            data_q    <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            pending_q <= pending_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            data_q    <= data_d;
        end
    end

    // Storage is qualified by the pointers and count, so it needs no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign alu_ready       = grant_alu;
    assign lsu_ready       = !fifo_full;
    assign fifo_count      = count_q;
    assign pending         = pending_q;
    assign rf_write_enable = we_q;
    assign rf_write_select = sel_q;
    assign rf_data_in      = data_q;

endmodule
